// File: rtl/enable_gen_pkg.sv
// Shared types and helpers for the multi-channel enable generator.
// Config words are held at CFG_W bits; upper bits beyond DIV_W stay zero.
package enable_gen_pkg;

  localparam int CFG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN
  } ch_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
    logic             oneshot;
  } ch_cfg_t;

  function automatic int calc_div(input int clk_freq, input int en_freq);
    return $rtoi(real'(clk_freq) / real'(en_freq)) - 1;
  endfunction

endpackage

// File: rtl/enable_gen_channel.sv
// One enable channel: shadow/active config, IDLE/DELAY/RUN FSM,
// phase delay counter and period counter with registered outputs.
module enable_gen_channel
  import enable_gen_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 99_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             en_o,
  output logic             busy_o
);

  localparam ch_cfg_t DEF_CFG = '{
    div:     CFG_W'(DEFAULT_DIV),
    phase:   '0,
    oneshot: 1'b0
  };

  ch_state_t        state_q;
  ch_cfg_t          shd_q, shd_d, act_q;
  logic [DIV_W-1:0] cnt_q, dly_q;
  logic             en_q, busy_q;
  logic             wrap, phase_hit;

  // Shadow next value: a write on this edge wins over the held value.
  always_comb begin
    shd_d = shd_q;
    if (wr_i) begin
      shd_d.div     = CFG_W'(div_i);
      shd_d.phase   = CFG_W'(phase_i);
      shd_d.oneshot = oneshot_i;
    end
  end

  // End-of-period and end-of-delay detection against the active config.
  always_comb begin
    wrap      = (CFG_W'(cnt_q) == act_q.div);
    phase_hit = (CFG_W'(dly_q) == act_q.phase);
  end

  // Channel FSM: stop beats start, start resyncs from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shd_q   <= DEF_CFG;
      act_q   <= DEF_CFG;
      cnt_q   <= '0;
      dly_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shd_q <= shd_d;
      if (stop_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        dly_q   <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_i) begin
        act_q  <= shd_d;
        cnt_q  <= '0;
        dly_q  <= DIV_W'(1);
        en_q   <= 1'b0;
        busy_q <= 1'b1;
        if (shd_d.phase != '0) state_q <= DELAY;
        else                   state_q <= RUN;
      end else begin
        case (state_q)
          IDLE: begin
            en_q <= 1'b0;
          end
          DELAY: begin
            en_q <= 1'b0;
            if (phase_hit) begin
              state_q <= RUN;
              cnt_q   <= '0;
            end else begin
              dly_q <= dly_q + DIV_W'(1);
            end
          end
          RUN: begin
            if (wrap) begin
              en_q  <= 1'b1;
              cnt_q <= '0;
              act_q <= shd_q;
              if (act_q.oneshot) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              en_q  <= 1'b0;
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_o   = en_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/enable_gen_multi.sv
// Multi-channel programmable enable generator: config decode
// and one independent enable_gen_channel per output bit.
module enable_gen_multi
  import enable_gen_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int EN_FREQ     = 1_000,
  parameter int N_CH        = 4,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = calc_div(CLK_FREQ, EN_FREQ),
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             cfg_oneshot,
  input  logic [N_CH-1:0]  start_i,
  input  logic [N_CH-1:0]  stop_i,
  output logic [N_CH-1:0]  en_o,
  output logic [N_CH-1:0]  busy_o
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("enable_gen_multi: N_CH must be 1..16");
  end

  if (DIV_W < 1 || DIV_W > CFG_W) begin : g_bad_divw
    $error("enable_gen_multi: DIV_W must be 1..32");
  end

  if (DEFAULT_DIV < 0 ||
      longint'(DEFAULT_DIV) >= (longint'(1) << DIV_W)) begin : g_bad_div
    $error("enable_gen_multi: DEFAULT_DIV does not fit DIV_W");
  end

  logic [N_CH-1:0] wr_sel;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Out-of-range cfg_ch values match no channel and are dropped.
    assign wr_sel[g] = cfg_wr && (cfg_ch == CH_W'(g));

    enable_gen_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr_sel[g]),
      .div_i     (cfg_div),
      .phase_i   (cfg_phase),
      .oneshot_i (cfg_oneshot),
      .start_i   (start_i[g]),
      .stop_i    (stop_i[g]),
      .en_o      (en_o[g]),
      .busy_o    (busy_o[g])
    );
  end

endmodule

// File: tb/tb_enable_gen_multi.sv
// Directed bench for enable_gen_multi: per-edge vector table
// plus hand-written restart and async-reset sequences.
module tb_enable_gen_multi;

  localparam int N_CH  = 4;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic             cfg_oneshot = 1'b0;
  logic [N_CH-1:0]  start_i = '0;
  logic [N_CH-1:0]  stop_i = '0;
  logic [N_CH-1:0]  en_o;
  logic [N_CH-1:0]  busy_o;

  int n_cmp = 0;
  int n_err = 0;

  enable_gen_multi #(
    .CLK_FREQ (1000),
    .EN_FREQ  (250),
    .N_CH     (N_CH),
    .DIV_W    (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_phase   (cfg_phase),
    .cfg_oneshot (cfg_oneshot),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .en_o        (en_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  start;
    logic [3:0]  stop;
    logic        wr;
    logic [1:0]  ch;
    logic [23:0] div;
    logic [23:0] phase;
    logic        os;
    logic [3:0]  en;
    logic [3:0]  busy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(
    input logic [3:0] start, input logic [3:0] stop,
    input logic wr, input logic [1:0] ch,
    input int div, input int phase, input logic os,
    input logic [3:0] en, input logic [3:0] busy);
    vec_t r;
    r.start = start; r.stop = stop;
    r.wr = wr; r.ch = ch;
    r.div = 24'(div); r.phase = 24'(phase); r.os = os;
    r.en = en; r.busy = busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t x);
    start_i     = x.start;
    stop_i      = x.stop;
    cfg_wr      = x.wr;
    cfg_ch      = x.ch;
    cfg_div     = x.div;
    cfg_phase   = x.phase;
    cfg_oneshot = x.os;
  endtask

  task automatic idle_inputs();
    start_i = '0;
    stop_i  = '0;
    cfg_wr  = 1'b0;
  endtask

  initial begin
    // index = edge number; inputs sampled at that edge, outputs after it
    //           start  stop   wr ch div ph os  en     busy
    tbl[0]  = v(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[1]  = v(4'b0100, 4'b0000, 1, 2, 0, 0, 0, 4'b0000, 4'b0101);
    tbl[2]  = v(4'b0000, 4'b0000, 1, 1, 2, 5, 1, 4'b0100, 4'b0101);
    tbl[3]  = v(4'b1000, 4'b1000, 0, 0, 0, 0, 0, 4'b0100, 4'b0101);
    tbl[4]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0101, 4'b0101);
    tbl[5]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 4'b0101);
    tbl[6]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 4'b0101);
    tbl[7]  = v(4'b0000, 4'b0100, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[8]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0001);
    tbl[9]  = v(4'b0000, 4'b0000, 1, 0, 1, 0, 0, 4'b0000, 4'b0001);
    tbl[10] = v(4'b0010, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tbl[11] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tbl[12] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0011);
    tbl[13] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tbl[14] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0011);
    tbl[15] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tbl[16] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0011);
    tbl[17] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0011);
    tbl[18] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0011, 4'b0001);
    tbl[19] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[20] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0001);
    tbl[21] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[22] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0001);
    tbl[23] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[24] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 4'b0001);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_en", en_o, 4'b0000);
    check("reset_busy", busy_o, 4'b0000);

    for (int e = 0; e < 25; e++) begin
      drive(tbl[e]);
      step();
      check($sformatf("tbl_en_e%0d", e), en_o, tbl[e].en);
      check($sformatf("tbl_busy_e%0d", e), busy_o, tbl[e].busy);
    end
    idle_inputs();

    // ch0 now D=1; edge 26 would pulse, restart there with D=3
    step();
    check("pre_restart_en", en_o, 4'b0000);
    start_i     = 4'b0001;
    cfg_wr      = 1'b1;
    cfg_ch      = 2'd0;
    cfg_div     = 24'd3;
    cfg_phase   = 24'd0;
    cfg_oneshot = 1'b0;
    step();
    idle_inputs();
    check("restart_edge_en", en_o, 4'b0000);
    check("restart_edge_busy", busy_o, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("restart_en_k%0d", k), en_o,
            (k == 4) ? 4'b0001 : 4'b0000);
    end

    // en_o[0] is high here; assert reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_en", en_o, 4'b0000);
    check("async_rst_busy", busy_o, 4'b0000);
    #2;
    rst = 1'b0;

    // defaults restored: D=3, P=0, periodic, phase-aligned ch0/ch1
    start_i = 4'b0011;
    step();
    idle_inputs();
    check("post_rst_busy", busy_o, 4'b0011);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("post_rst_en_k%0d", k), en_o,
            (k == 4 || k == 8) ? 4'b0011 : 4'b0000);
    end
    check("post_rst_busy_end", busy_o, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enable_gen_multi.md
Name: enable_gen_multi

Overview:
Multi-channel programmable enable (tick) generator. It replaces fixed-rate single-channel enable generation wherever several rates or phases are needed, e.g. ADC sample strobes, UART baud ticks and LED blink timing. Each channel has a runtime-programmable divider, a start phase offset, and periodic or one-shot mode. Start and stop are controlled per channel, so channels can be launched phase-aligned.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
EN_FREQ, 1_000, reset-default enable frequency for every channel
N_CH, 4, number of independent channels (1..16)
DIV_W, 24, width of divider and phase registers
DEFAULT_DIV, $rtoi(real'(CLK_FREQ)/real'(EN_FREQ))-1, reset value of each channel's divider; elaboration error if it is >= 2**DIV_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_wr  in  1  write strobe for the channel config selected by cfg_ch
cfg_ch  in  $clog2(N_CH) (min 1)  target channel of cfg_wr
cfg_div  in  DIV_W  divider D; period = D+1 clk cycles
cfg_phase  in  DIV_W  delay P in cycles inserted before counting after start
cfg_oneshot  in  1  1 = single pulse then stop; 0 = periodic
start_i  in  N_CH  per-channel start/restart strobe
stop_i  in  N_CH  per-channel synchronous abort
en_o  out  N_CH  registered 1-cycle enable pulses
busy_o  out  N_CH  channel in DELAY or RUN

Behaviour:
- Reset: all channels IDLE; en_o=0, busy_o=0, counters=0; div=DEFAULT_DIV, phase=0, oneshot=0 (shadow and active).
- Config: cfg_wr writes the shadow regs of channel cfg_ch. cfg_ch >= N_CH is ignored.
- Shadow to active copy: on start, or at each RUN wrap (count==div). A config write therefore never corrupts a period in progress.
- Per-channel states: IDLE, DELAY, RUN.
  - IDLE + start: load active from shadow (the same-edge cfg_wr value wins), count<=0. Go to DELAY with phase_cnt<=P if P>0, else go to RUN.
  - DELAY: phase_cnt decrements each cycle. When phase_cnt==1, go to RUN with count<=0.
  - RUN: if count==div then en_o<=1 and count<=0, and go to IDLE if oneshot. Otherwise count<=count+1 and en_o<=0.
- Latency: with start sampled at edge 0, en_o rises at edge P+D+1. Each pulse lasts exactly 1 cycle, and periodic pulses repeat every D+1 cycles.
- D=0 in RUN gives en_o high every cycle (continuous).
- Start while in DELAY or RUN restarts the channel from scratch (resync). No pulse is emitted on the restart edge.
- Stop: next edge gives IDLE, en_o=0, busy_o=0, and any pending pulse is discarded. Stop and start on the same edge: stop wins.
- busy_o is registered. It is 1 from the edge after start. In oneshot mode it falls on the same edge en_o rises.
- Channels are fully independent. The same start_i edge on several channels with equal D and P gives coincident pulses forever.
- Counter width is DIV_W. No wrap beyond div is possible.

Decomposition:
- Package enable_gen_pkg holds:
  - ch_state_t enum {IDLE, DELAY, RUN}
  - ch_cfg_t struct {div, phase, oneshot}
  - helper function calc_div(clk_freq, en_freq)
- Sub-module enable_gen_channel holds one channel's shadow and active cfg, FSM and counters. The top level does cfg_ch decode and a generate loop over N_CH.

Test Plan:
1. Reset defaults, CLK_FREQ=1000, EN_FREQ=250 (DEFAULT_DIV=3), start_i[0] at edge 0 -> en_o[0] pulses at edges 4, 8, 12; other channels stay 0.
2. ch1 cfg D=2, P=5, oneshot=1, start at edge 10 -> single en_o[1] pulse at edge 18; busy_o[1] high after edges 11..17, low from edge 18.
3. ch2 D=0 periodic -> en_o[2] high every cycle from edge 2; stop at edge 6 -> en_o[2]=0 from edge 7.
4. ch0 running D=3; cfg_wr D=1 mid-period -> current period completes at D=3, then pulses every 2 cycles.
5. start_i and stop_i both asserted on ch3 -> ch3 stays IDLE, no pulse. Restart ch0 mid-count -> next pulse D+1 edges after the restart edge.
6. Async rst asserted mid-RUN between edges -> en_o and busy_o drop immediately, default config restored.
